// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave = the load/store unit; master = requester plus memory.
interface load_store_unit_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;

   modport slave (
      input  req, we, size, uns, addr, wdata, mem_rdata,
      output ready, done, err, rdata, mem_addr, mem_wdata, mem_read, mem_write
   );

   modport master (
      output req, we, size, uns, addr, wdata, mem_rdata,
      input  ready, done, err, rdata, mem_addr, mem_wdata, mem_read, mem_write
   );
endinterface

// File: rtl/load_store_unit.sv
// Sub-word load/store controller in front of a word-wide data memory:
// read-modify-write for byte/half stores, sign/zero-extended loads, access checks.
module load_store_unit #(
   parameter int MEM_WORDS = 32
) (
   input  logic               clk,
   input  logic               rst,
   load_store_unit_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state, state_nx;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        we_q;
   logic        uns_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] word_q;

   logic        accept;
   logic        bad;
   logic [4:0]  sh;
   logic [31:0] mask;
   logic [31:0] shifted;
   logic [31:0] ext;
   logic [31:0] merged;

   assign accept = bus.req && (state == IDLE);

   always_comb begin
      bad = 1'b0;
      if (bus.size == 2'b11)                              bad = 1'b1;
      if ((bus.size == 2'b01) && bus.addr[0])             bad = 1'b1;
      if ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00)) bad = 1'b1;
      if ({2'b00, bus.addr[31:2]} >= 32'(MEM_WORDS))      bad = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) begin
            if (bad)                                state_nx = RESP;
            else if (!bus.we || bus.size != 2'b10)  state_nx = RD;
            else                                    state_nx = WR;
         end
         RD:      state_nx = we_q ? WR : RESP;
         WR:      state_nx = RESP;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         word_q  <= '0;
      end else begin
         if (accept) begin
            addr_q  <= bus.addr;
            size_q  <= bus.size;
            we_q    <= bus.we;
            uns_q   <= bus.uns;
            wdata_q <= bus.wdata;
            err_q   <= bad;
         end
         if (state == RD) word_q <= bus.mem_rdata;
      end
   end

   // Lane shift is shared by load extraction and store merge.
   always_comb begin
      sh      = (size_q == 2'b01) ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
      mask    = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
      shifted = word_q >> sh;
      case (size_q)
         2'b00:   ext = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: ext = word_q;
      endcase
      if (size_q == 2'b10) merged = wdata_q;
      else                 merged = (word_q & ~(mask << sh)) | ((wdata_q & mask) << sh);
   end

   always_comb begin
      bus.ready     = (state == IDLE) && rst;
      bus.done      = (state == RESP);
      bus.err       = (state == RESP) && err_q;
      bus.rdata     = ((state == RESP) && !we_q && !err_q) ? ext : '0;
      bus.mem_read  = (state == RD);
      bus.mem_write = (state == WR);
      bus.mem_addr  = ((state == RD) || (state == WR)) ? {addr_q[31:2], 2'b00} : '0;
      bus.mem_wdata = (state == WR) ? merged : '0;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 32-word data memory model.
module tb_load_store_unit;

   logic clk;
   logic rst;
   logic mem_clear;
   logic [31:0] mem [0:31];

   int n_checks;
   int n_errors;

   load_store_unit_if bus();

   load_store_unit #(.MEM_WORDS(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[6:2]] : 32'h0;

   always @(negedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
         mem[0] <= 32'h0000_000F;
         mem[1] <= 32'h0000_000A;
      end else if (bus.mem_write) begin
         mem[bus.mem_addr[6:2]] <= bus.mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic mem_reset();
      @(posedge clk);
      #1 mem_clear = 1'b1;
      @(negedge clk);
      #1 mem_clear = 1'b0;
   endtask

   // Issue one request, then watch up to 10 cycles for done.
   task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic e,
                          output int nrd, output int nwr);
      int n;
      n = 0; lat = -1; rd = 'x; e = 1'bx; nrd = 0; nwr = 0;
      @(negedge clk);
      while (!bus.ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = wd;
      @(posedge clk);
      #1 bus.req = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (bus.mem_read)  nrd++;
         if (bus.mem_write) nwr++;
         if (bus.done) begin
            lat = c; rd = bus.rdata; e = bus.err;
            break;
         end
      end
   endtask

   task automatic do_load(input string tag, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] exp);
      int lat, nrd, nwr;
      logic [31:0] rd;
      logic e;
      run_req(1'b0, sz, u, a, 32'h0, lat, rd, e, nrd, nwr);
      check({tag, " lat"},   32'(lat), 32'd2);
      check({tag, " rdata"}, rd, exp);
      check({tag, " err"},   32'(e), 32'd0);
      check({tag, " reads"}, 32'(nrd), 32'd1);
      check({tag, " writes"}, 32'(nwr), 32'd0);
   endtask

   task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input int exp_lat, input int exp_rd);
      int lat, nrd, nwr;
      logic [31:0] rd;
      logic e;
      run_req(1'b1, sz, 1'b0, a, wd, lat, rd, e, nrd, nwr);
      check({tag, " lat"},    32'(lat), 32'(exp_lat));
      check({tag, " err"},    32'(e), 32'd0);
      check({tag, " rdata"},  rd, 32'h0);
      check({tag, " reads"},  32'(nrd), 32'(exp_rd));
      check({tag, " writes"}, 32'(nwr), 32'd1);
   endtask

   task automatic do_bad(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a);
      int lat, nrd, nwr;
      logic [31:0] rd;
      logic e;
      run_req(w, sz, 1'b0, a, 32'hFFFF_FFFF, lat, rd, e, nrd, nwr);
      check({tag, " lat"},    32'(lat), 32'd1);
      check({tag, " err"},    32'(e), 32'd1);
      check({tag, " rdata"},  rd, 32'h0);
      check({tag, " reads"},  32'(nrd), 32'd0);
      check({tag, " writes"}, 32'(nwr), 32'd0);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " ready"},     32'(bus.ready), 32'd0);
      check({tag, " done"},      32'(bus.done), 32'd0);
      check({tag, " err"},       32'(bus.err), 32'd0);
      check({tag, " rdata"},     bus.rdata, 32'h0);
      check({tag, " mem_read"},  32'(bus.mem_read), 32'd0);
      check({tag, " mem_write"}, 32'(bus.mem_write), 32'd0);
      check({tag, " mem_addr"},  bus.mem_addr, 32'h0);
      check({tag, " mem_wdata"}, bus.mem_wdata, 32'h0);
   endtask

   initial begin
      int done_cyc [2];
      logic [31:0] done_val [2];
      int ndone, nrd, nwr;
      logic acc_next;

      n_checks = 0; n_errors = 0;
      rst = 1'b0; mem_clear = 1'b1;
      bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
      bus.addr = 32'h0; bus.wdata = 32'h0;

      #3 check_quiet("reset");
      @(negedge clk);
      #1 mem_clear = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 check("ready after reset", 32'(bus.ready), 32'd1);

      mem_reset();
      do_load("lw 0x0", 2'b10, 1'b0, 32'h0, 32'h0000_000F);

      do_store("sb 0x5", 2'b00, 32'h5, 32'h0000_0080, 3, 1);
      check("mem1 after sb", mem[1], 32'h0000_800A);
      do_load("lb 0x5",  2'b00, 1'b0, 32'h5, 32'hFFFF_FF80);
      do_load("lbu 0x5", 2'b00, 1'b1, 32'h5, 32'h0000_0080);
      do_load("lw 0x4",  2'b10, 1'b0, 32'h4, 32'h0000_800A);

      mem_reset();
      do_store("sh 0x2", 2'b01, 32'h2, 32'h1234_BEEF, 3, 1);
      check("mem0 after sh", mem[0], 32'hBEEF_000F);
      do_load("lh 0x2",  2'b01, 1'b0, 32'h2, 32'hFFFF_BEEF);
      do_load("lhu 0x0", 2'b01, 1'b1, 32'h0, 32'h0000_000F);

      do_store("sw 0x8", 2'b10, 32'h8, 32'hCAFE_F00D, 2, 0);
      check("mem2 after sw", mem[2], 32'hCAFE_F00D);
      do_load("lbu 0xB", 2'b00, 1'b1, 32'hB, 32'h0000_00CA);
      do_load("lb 0x7c", 2'b00, 1'b0, 32'h7C, 32'h0000_0000);

      do_bad("lw 0x6",    1'b0, 2'b10, 32'h6);
      do_bad("sh 0x3",    1'b1, 2'b01, 32'h3);
      do_bad("size 11",   1'b0, 2'b11, 32'h0);
      do_bad("lw 0x80",   1'b0, 2'b10, 32'h80);

      // Reset during WR of a word store, before the write negedge.
      mem_reset();
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.uns = 1'b0;
      bus.addr = 32'h4; bus.wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 bus.req = 1'b0;
      check("rst-in-WR mem_write before", 32'(bus.mem_write), 32'd1);
      #1 rst = 1'b0;
      #1 check_quiet("rst-in-WR");
      @(negedge clk);
      #1 check("rst-in-WR mem1", mem[1], 32'h0000_000A);
      @(negedge clk);
      rst = 1'b1;
      #1 check("ready after rst release", 32'(bus.ready), 32'd1);

      // Held request while busy: second access starts only once ready.
      mem_reset();
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.uns = 1'b0;
      bus.addr = 32'h0; bus.wdata = 32'h1111_1111;
      @(posedge clk);
      #1 bus.addr = 32'h4; bus.wdata = 32'h2222_2222;
      ndone = 0; nrd = 0; nwr = 0; acc_next = 1'b0;
      done_cyc[0] = -1; done_cyc[1] = -1; done_val[0] = 'x; done_val[1] = 'x;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (bus.mem_read)  nrd++;
         if (bus.mem_write) nwr++;
         if (bus.done) begin
            if (ndone < 2) begin
               done_cyc[ndone] = c;
               done_val[ndone] = bus.rdata;
            end
            ndone++;
         end
         if (bus.ready && bus.req) acc_next = 1'b1;
         @(posedge clk);
         #1 if (acc_next) begin
            bus.req = 1'b0;
            acc_next = 1'b0;
         end
      end
      bus.req = 1'b0;
      check("busy done count", 32'(ndone), 32'd2);
      check("busy first done cycle", 32'(done_cyc[0]), 32'd2);
      check("busy done spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd3);
      check("busy rdata 0", done_val[0], 32'h0000_000F);
      check("busy rdata 1", done_val[1], 32'h0000_000A);
      check("busy reads", 32'(nrd), 32'd2);
      check("busy writes", 32'(nwr), 32'd0);
      check("busy mem untouched", mem[1], 32'h0000_000A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000 expected earlier");
      $fatal(1);
   end

endmodule
